// File: rtl/mult_feeder.sv
// mult_feeder: sequences neuron loading, weight issue and result capture for parallel_mult
module mult_feeder #(
    parameter int NUM_IN   = 16,
    parameter int DATA_W   = 16,
    parameter int NUM_OUT  = 16,
    parameter int MULT_LAT = 2,
    localparam int IDX_W   = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             nrn_valid,
    output logic                             nrn_ready,
    input  logic [DATA_W-1:0]                nrn_data,
    input  logic                             wt_valid,
    output logic                             wt_ready,
    input  logic [NUM_IN-1:0]                wt_data,
    output logic [NUM_IN-1:0][DATA_W-1:0]    input_neuron,
    output logic [NUM_IN-1:0]                weight_bits,
    output logic                             en,
    input  logic [DATA_W-1:0]                mult_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [DATA_W-1:0]                res_data,
    output logic [IDX_W-1:0]                 res_idx,
    output logic                             busy,
    output logic                             done
);
    localparam int NI_W = $clog2(NUM_IN);

    typedef enum logic [2:0] {IDLE, LOAD, WEIGHT, WAIT, RESULT, DONE} state_t;

    state_t            state, state_n;
    logic [NI_W-1:0]   ni;
    logic [IDX_W-1:0]  oi;
    logic [3:0]        wc;
    logic              last_nrn, lat_hit, last_out;

    assign last_nrn = ni == NI_W'(NUM_IN - 1);
    assign lat_hit  = wc == 4'(MULT_LAT);
    assign last_out = oi == IDX_W'(NUM_OUT - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state decode; start is only honoured in IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = nrn_valid && last_nrn ? WEIGHT : LOAD;
            WEIGHT:  state_n = wt_valid ? WAIT : WEIGHT;
            WAIT:    state_n = lat_hit ? RESULT : WAIT;
            RESULT:  state_n = res_ready ? (last_out ? DONE : WEIGHT) : RESULT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // registered handshake/status outputs, counters and captured operands/results
    always_ff @(posedge clk) begin
        if (rst) begin
            nrn_ready    <= 1'b0;
            wt_ready     <= 1'b0;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            en           <= 1'b0;
            input_neuron <= '0;
            weight_bits  <= '0;
            res_data     <= '0;
            res_idx      <= '0;
            ni           <= '0;
            oi           <= '0;
            wc           <= '0;
        end else begin
            nrn_ready <= state_n == LOAD;
            wt_ready  <= state_n == WEIGHT;
            res_valid <= state_n == RESULT;
            busy      <= state_n != IDLE;
            done      <= state_n == DONE;
            en        <= state == WEIGHT && wt_valid;
            if (state == IDLE && start) begin
                ni <= '0;
                oi <= '0;
            end
            if (state == LOAD && nrn_valid) begin
                input_neuron[ni] <= nrn_data;
                ni               <= ni + 1'b1;
            end
            if (state == WEIGHT && wt_valid) begin
                weight_bits <= wt_data;
                wc          <= '0;
            end
            if (state == WAIT) begin
                wc <= wc + 1'b1;
                if (lat_hit) begin
                    res_data <= mult_out;
                    res_idx  <= oi;
                end
            end
            if (state == RESULT && res_ready && !last_out) oi <= oi + 1'b1;
        end
    end
endmodule
